// File: rtl/ble_dma_pkg.sv
// Shared definitions for the BLE DMA request/acknowledge flow controller.
package ble_dma_pkg;

  // Width of every channel index (grant_id, timeout_ch, round-robin pointer).
  localparam int CH_W = 3;

  // Channel direction encoding on ch_dir.
  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

  // Controller states; exported on dbg_state for observation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/ble_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel at or after ptr_i,
// wrapping back to channel 0 when nothing at or above the pointer is eligible.
module ble_rr_arbiter
  import ble_dma_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]  elig_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [CH_W-1:0] grant_o,
  output logic            valid_o
);

  logic [CH_W-1:0] hi_idx;
  logic            hi_vld;
  logic [CH_W-1:0] lo_idx;
  logic            lo_vld;

  // Scan downwards so the last hit is the lowest index in each half.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    lo_vld = 1'b0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (elig_i[c]) begin
        lo_idx = CH_W'(c);
        lo_vld = 1'b1;
        if (c >= int'(ptr_i)) begin
          hi_idx = CH_W'(c);
          hi_vld = 1'b1;
        end
      end
    end
    grant_o = hi_vld ? hi_idx : lo_idx;
    valid_o = lo_vld;
  end

endmodule

// File: rtl/ble_dma_flow_ctrl.sv
// DMA request/acknowledge controller for NCH shared-memory FIFO channels.
// Handshake: dma_req is held one-hot for the granted channel until a
// single-cycle dma_ack accepts it; after that dma_beat marks each word moved
// and the burst closes on the latched beat count or on dma_done.
module ble_dma_flow_ctrl
  import ble_dma_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int LVL_W   = 7,
  parameter int BURST_W = 8,
  parameter int TO_W    = 16
) (
  input  logic                   hclk,
  input  logic                   reset,
  input  logic                   dma_mode,
  input  logic [NCH-1:0]         ch_enable,
  input  logic [NCH-1:0]         ch_dir,
  input  logic [NCH*LVL_W-1:0]   fifo_level,
  input  logic [NCH*LVL_W-1:0]   watermark,
  input  logic [NCH*BURST_W-1:0] burst_len,
  input  logic [TO_W-1:0]        timeout_limit,
  input  logic                   dma_ack,
  input  logic                   dma_beat,
  input  logic                   dma_done,
  input  logic                   irq_clear,
  output logic [NCH-1:0]         dma_req,
  output logic [CH_W-1:0]        grant_id,
  output logic                   busy,
  output logic                   burst_done,
  output logic                   timeout_irq,
  output logic [CH_W-1:0]        timeout_ch,
  output dma_state_e             dbg_state
);

  dma_state_e         state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic               irq_q;
  logic [CH_W-1:0]    irq_ch_q;

  logic [NCH-1:0]     elig;
  logic [CH_W-1:0]    arb_grant;
  logic               arb_valid;
  logic [BURST_W-1:0] pick_len;
  logic               gnt_en;
  logic [CH_W-1:0]    nxt_ptr;
  logic               to_fire;
  logic [TO_W:0]      to_inc;
  logic [BURST_W:0]   beat_sum;

  // Per-channel eligibility: TX wants refill at/below watermark, RX wants
  // draining at/above watermark, with an empty RX FIFO never requesting.
  for (genvar c = 0; c < NCH; c++) begin : g_elig
    logic [LVL_W-1:0] lvl;
    logic [LVL_W-1:0] wm;
    logic [LVL_W-1:0] rx_thr;
    assign lvl     = fifo_level[c*LVL_W +: LVL_W];
    assign wm      = watermark[c*LVL_W +: LVL_W];
    assign rx_thr  = (wm == '0) ? LVL_W'(1) : wm;
    assign elig[c] = dma_mode & ch_enable[c] &
                     ((ch_dir[c] == DIR_TX) ? (lvl <= wm) : (lvl >= rx_thr));
  end

  ble_rr_arbiter #(.NCH(NCH)) u_arb (
    .elig_i  (elig),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  // Per-channel field selection for the arbiter pick and the held grant.
  always_comb begin
    pick_len = '0;
    gnt_en   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (arb_grant == CH_W'(c)) pick_len = burst_len[c*BURST_W +: BURST_W];
      if (grant_q == CH_W'(c))   gnt_en   = ch_enable[c];
    end
  end

  assign nxt_ptr  = (grant_q == CH_W'(NCH - 1)) ? '0 : grant_q + CH_W'(1);
  assign to_inc   = {1'b0, to_q} + (TO_W + 1)'(1);
  assign beat_sum = {1'b0, beat_q} + (BURST_W + 1)'(dma_beat);

  // Next-state logic: grant, request wait with abort/timeout, burst count.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    beat_d  = beat_q;
    to_d    = to_q;
    rr_d    = rr_q;
    to_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          len_d   = pick_len;
          to_d    = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        to_d = to_inc[TO_W-1:0];
        if (dma_ack) begin
          beat_d  = '0;
          state_d = ST_XFER;
        end else if (!gnt_en || !dma_mode) begin
          state_d = ST_IDLE;
        end else if (timeout_limit != '0 && to_inc == {1'b0, timeout_limit}) begin
          to_fire = 1'b1;
          rr_d    = nxt_ptr;
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        // Saturation only matters for open-ended bursts (len 0).
        if (dma_beat && beat_q != '1) beat_d = beat_sum[BURST_W-1:0];
        if ((len_q != '0 && beat_sum == {1'b0, len_q}) || dma_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        rr_d    = nxt_ptr;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      rr_q    <= rr_d;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge hclk) begin
    if (reset) begin
      irq_q    <= 1'b0;
      irq_ch_q <= '0;
    end else if (to_fire) begin
      irq_q    <= 1'b1;
      irq_ch_q <= grant_q;
    end else if (irq_clear) begin
      irq_q    <= 1'b0;
      irq_ch_q <= '0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    for (int c = 0; c < NCH; c++) dma_req[c] = (state_q == ST_REQ) && (grant_q == CH_W'(c));
  end

  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign burst_done  = (state_q == ST_DONE);
  assign timeout_irq = irq_q;
  assign timeout_ch  = irq_ch_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ble_dma_flow_ctrl.sv
// Bench for ble_dma_flow_ctrl: directed scenarios plus randomized bursts,
// with expected grants/completions/timeouts queued and checked by a monitor.
module tb_ble_dma_flow_ctrl;
  import ble_dma_pkg::*;

  localparam int NCH     = 2;
  localparam int LVL_W   = 7;
  localparam int BURST_W = 8;
  localparam int TO_W    = 16;
  localparam int RW      = CH_W + NCH;

  // ---------------- clock / reset / DUT ----------------
  logic                   hclk = 1'b0;
  logic                   reset;
  logic                   dma_mode;
  logic [NCH-1:0]         ch_enable;
  logic [NCH-1:0]         ch_dir;
  logic [NCH*LVL_W-1:0]   fifo_level;
  logic [NCH*LVL_W-1:0]   watermark;
  logic [NCH*BURST_W-1:0] burst_len;
  logic [TO_W-1:0]        timeout_limit;
  logic                   dma_ack, dma_beat, dma_done, irq_clear;
  logic [NCH-1:0]         dma_req;
  logic [CH_W-1:0]        grant_id, timeout_ch;
  logic                   busy, burst_done, timeout_irq;
  dma_state_e             dbg_state;

  always #5 hclk = ~hclk;

  ble_dma_flow_ctrl #(.NCH(NCH), .LVL_W(LVL_W), .BURST_W(BURST_W), .TO_W(TO_W)) dut (
    .hclk(hclk), .reset(reset), .dma_mode(dma_mode), .ch_enable(ch_enable),
    .ch_dir(ch_dir), .fifo_level(fifo_level), .watermark(watermark),
    .burst_len(burst_len), .timeout_limit(timeout_limit), .dma_ack(dma_ack),
    .dma_beat(dma_beat), .dma_done(dma_done), .irq_clear(irq_clear),
    .dma_req(dma_req), .grant_id(grant_id), .busy(busy), .burst_done(burst_done),
    .timeout_irq(timeout_irq), .timeout_ch(timeout_ch), .dbg_state(dbg_state)
  );

  // Per-channel configuration in plain integers, packed onto the buses.
  int lvl[NCH];
  int wm[NCH];
  int blen[NCH];

  always_comb begin
    fifo_level = '0;
    watermark  = '0;
    burst_len  = '0;
    for (int c = 0; c < NCH; c++) begin
      fifo_level[c*LVL_W +: LVL_W]  = LVL_W'(lvl[c]);
      watermark[c*LVL_W +: LVL_W]   = LVL_W'(wm[c]);
      burst_len[c*BURST_W +: BURST_W] = BURST_W'(blen[c]);
    end
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0]   exp_req_q[$];
  logic [CH_W-1:0] exp_done_q[$];
  logic [CH_W-1:0] exp_to_q[$];
  int m_rr = 0;   // model: channel to try first on the next arbitration

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: which channels want service under the current configuration.
  function automatic bit model_elig(int c);
    int rx_min;
    rx_min = (wm[c] > 1) ? wm[c] : 1;
    if (!dma_mode || !ch_enable[c]) return 1'b0;
    if (ch_dir[c]) return lvl[c] <= wm[c];
    return lvl[c] >= rx_min;
  endfunction

  // Reference round robin: first wanting channel starting from m_rr.
  function automatic int pick();
    for (int k = 0; k < NCH; k++) begin
      if (model_elig((m_rr + k) % NCH)) return (m_rr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [RW-1:0] req_word(int ch);
    logic [NCH-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    return {CH_W'(ch), oh};
  endfunction

  // ---------------- monitor ----------------
  logic [NCH-1:0] prev_req = '0;
  logic           prev_irq = 1'b0;

  always @(negedge hclk) begin
    if (dma_req != '0) check("req_onehot", $countones(dma_req), 1);
    if (dma_req != '0 && prev_req == '0) begin
      if (exp_req_q.size() == 0) check("req_unexpected", int'({grant_id, dma_req}), -1);
      else check("req_grant", int'({grant_id, dma_req}), int'(exp_req_q.pop_front()));
    end
    if (burst_done) begin
      if (exp_done_q.size() == 0) check("done_unexpected", int'(grant_id), -1);
      else check("done_ch", int'(grant_id), int'(exp_done_q.pop_front()));
    end
    if (timeout_irq && !prev_irq) begin
      if (exp_to_q.size() == 0) check("timeout_unexpected", int'(timeout_ch), -1);
      else check("timeout_ch", int'(timeout_ch), int'(exp_to_q.pop_front()));
    end
    prev_req <= dma_req;
    prev_irq <= timeout_irq;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_req(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 30 && !ok) begin
      step();
      lat++;
      if (dma_req != '0) ok = 1'b1;
    end
    if (!ok) check("req_wait_expired", 0, 1);
  endtask

  // Idle cycles inside a transfer; stray acks must be ignored there.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      dma_ack = 1'($urandom_range(0, 1));
      step();
    end
    dma_ack = 1'b0;
  endtask

  task automatic run_burst(input bit drop_en, input int pre_beats, input bit fin_done,
                           input bit fin_beat, output int lat);
    int ch;
    bit ok;
    lat = 0;
    ch  = pick();
    if (ch < 0) return;
    exp_req_q.push_back(req_word(ch));
    wait_req(lat, ok);
    if (!ok) return;
    // Stray beats/done while still requesting must be ignored.
    repeat ($urandom_range(0, 2)) begin
      dma_beat = 1'($urandom_range(0, 1));
      dma_done = 1'($urandom_range(0, 1));
      step();
    end
    dma_beat = 1'b0;
    dma_done = 1'b0;
    dma_ack  = 1'b1;
    step();
    dma_ack = 1'b0;
    if (drop_en) ch_enable[ch] = 1'b0;
    for (int i = 0; i < pre_beats; i++) begin
      gap();
      dma_beat = 1'b1;
      step();
      dma_beat = 1'b0;
    end
    gap();
    exp_done_q.push_back(CH_W'(ch));
    dma_beat = fin_beat;
    dma_done = fin_done;
    step();
    dma_beat = 1'b0;
    dma_done = 1'b0;
    m_rr = (ch + 1) % NCH;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_rr  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int ch;
    int len;
    int pre;
    bit fd;
    bit fb;
    bit ok;

    reset = 1'b1; dma_mode = 1'b0; ch_enable = '0; ch_dir = '0;
    timeout_limit = '0; dma_ack = 1'b0; dma_beat = 1'b0; dma_done = 1'b0; irq_clear = 1'b0;
    for (int c = 0; c < NCH; c++) begin lvl[c] = 0; wm[c] = 0; blen[c] = 0; end

    // Reset values.
    do_reset();
    check("rst_req", int'(dma_req), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(burst_done), 0);
    check("rst_irq", int'(timeout_irq), 0);
    check("rst_to_ch", int'(timeout_ch), 0);

    // Single TX burst on ch0: latency, completion pulse, busy release.
    dma_mode = 1'b1; ch_dir = 2'b01; ch_enable = 2'b01;
    lvl[0] = 3; wm[0] = 4; blen[0] = 4;
    run_burst(1'b0, 3, 1'b0, 1'b1, lat);
    check("t1_latency", lat, 1);
    check("t1_done_pulse", int'(burst_done), 1);
    check("t1_busy_in_done", int'(busy), 0);
    lvl[0] = 10; ch_enable = '0;
    step();
    check("t1_done_single", int'(burst_done), 0);
    check("t1_busy_after", int'(busy), 0);

    // Both channels continuously eligible: grants alternate from ch0.
    do_reset();
    ch_dir = 2'b01; ch_enable = 2'b11;
    lvl[0] = 3; wm[0] = 4; lvl[1] = 5; wm[1] = 2;
    blen[0] = $urandom_range(1, 5); blen[1] = $urandom_range(1, 5);
    for (int i = 0; i < 4; i++) begin
      ch = pick();
      check("t2_grant_order", ch, i % 2);
      run_burst(1'b0, blen[ch] - 1, 1'b0, 1'b1, lat);
    end
    ch_enable = '0;
    step();

    // RX ch1 never acked: timeout after 10 request cycles, then set-over-clear.
    ch_enable = 2'b10; timeout_limit = 16'd10;
    ch = pick();
    exp_req_q.push_back(req_word(ch));
    exp_req_q.push_back(req_word(ch));
    exp_to_q.push_back(CH_W'(1));
    exp_to_q.push_back(CH_W'(1));
    wait_req(lat, ok);
    lat = 0;
    while (dma_req != '0 && lat < 50) begin step(); lat++; end
    check("t3_req_cycles", lat, 10);
    check("t3_irq", int'(timeout_irq), 1);
    check("t3_irq_ch", int'(timeout_ch), 1);
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    check("t3_irq_cleared", int'(timeout_irq), 0);
    check("t3_irq_ch_cleared", int'(timeout_ch), 0);
    check("t3_rereq", int'(dma_req), 2);
    repeat (9) step();
    irq_clear = 1'b1;
    step();
    irq_clear = 1'b0;
    ch_enable = '0;
    timeout_limit = '0;
    m_rr = (1 + 1) % NCH;
    check("t3_set_wins", int'(timeout_irq), 1);
    check("t3_set_ch", int'(timeout_ch), 1);
    check("t3_req_dropped", int'(dma_req), 0);
    step();

    // Open-ended burst: 3 beats, then a beat together with dma_done.
    ch_enable = 2'b01; lvl[0] = 3; wm[0] = 4; blen[0] = 0;
    run_burst(1'b0, 3, 1'b1, 1'b1, lat);
    // Early dma_done on a sized burst.
    blen[0] = 6;
    run_burst(1'b0, 2, 1'b1, 1'b0, lat);
    ch_enable = '0;
    step();

    // Channel disabled while requesting: request withdrawn, no completion.
    ch_enable = 2'b01; blen[0] = 3;
    exp_req_q.push_back(req_word(pick()));
    wait_req(lat, ok);
    ch_enable = '0;
    step();
    check("t5_req_dropped", int'(dma_req), 0);
    check("t5_busy", int'(busy), 0);
    repeat (3) step();
    check("t5_no_done", int'(burst_done), 0);

    // Channel disabled mid-transfer: burst still runs to its length.
    ch_enable = 2'b01;
    run_burst(1'b1, 2, 1'b0, 1'b1, lat);
    check("t6_done", int'(burst_done), 1);
    ch_enable = '0;
    step();

    // Reset in the middle of a transfer, then arbitration restarts at ch0.
    ch_enable = 2'b10; lvl[1] = 5; wm[1] = 2; blen[1] = 5;
    exp_req_q.push_back(req_word(pick()));
    wait_req(lat, ok);
    dma_ack = 1'b1; step(); dma_ack = 1'b0;
    dma_beat = 1'b1; step(); dma_beat = 1'b0;
    reset = 1'b1;
    step();
    check("t7_req", int'(dma_req), 0);
    check("t7_busy", int'(busy), 0);
    check("t7_grant", int'(grant_id), 0);
    check("t7_done", int'(burst_done), 0);
    check("t7_irq", int'(timeout_irq), 0);
    check("t7_state", int'(dbg_state), 0);
    m_rr = 0;
    ch_enable = 2'b11; lvl[0] = 3; wm[0] = 4; blen[0] = 2;
    reset = 1'b0;
    run_burst(1'b0, 1, 1'b0, 1'b1, lat);
    check("t7_post_reset_lat", lat, 1);
    ch_enable = '0;
    step();

    // Randomized configurations and burst endings against the model.
    for (int it = 0; it < 24; it++) begin
      dma_mode = ($urandom_range(0, 5) != 0);
      ch_enable = NCH'($urandom_range(0, 3));
      ch_dir    = NCH'($urandom_range(0, 3));
      for (int c = 0; c < NCH; c++) begin
        lvl[c] = $urandom_range(0, 12);
        wm[c]  = $urandom_range(0, 12);
        blen[c] = $urandom_range(0, 6);
      end
      ch = pick();
      if (ch < 0) continue;
      len = blen[ch];
      if (len == 0) begin
        pre = $urandom_range(0, 4); fd = 1'b1; fb = 1'($urandom_range(0, 1));
      end else if (len >= 2 && $urandom_range(0, 2) == 0) begin
        pre = $urandom_range(0, len - 2); fd = 1'b1; fb = 1'($urandom_range(0, 1));
      end else begin
        pre = len - 1; fd = 1'b0; fb = 1'b1;
      end
      run_burst(1'b0, pre, fd, fb, lat);
    end
    ch_enable = '0;
    repeat (5) step();

    check("end_req_q_empty", exp_req_q.size(), 0);
    check("end_done_q_empty", exp_done_q.size(), 0);
    check("end_to_q_empty", exp_to_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ble_dma_flow_ctrl.md
Name: ble_dma_flow_ctrl

Overview:
- Parametrised DMA request/acknowledge controller that replaces the single hard-wired TX request flag of the BLE chain top.
- Serves NCH FIFO channels, each configurable as TX (drain-side refill) or RX (fill-side empty).
- Raises requests from per-channel FIFO level vs. watermark and arbitrates round-robin onto one DMA port.
- Tracks each burst to completion and flags request timeouts.
- Sits between the shared-memory FIFOs and the AHB DMA controller, clocked on hclk.

Parameters:
- NCH, 2, number of FIFO channels (1..8).
- LVL_W, 7, width of FIFO level and watermark fields, in words.
- BURST_W, 8, width of the burst-length field and beat counter.
- TO_W, 16, width of the request-timeout counter.

Ports:
- hclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dma_mode  in  1  global DMA enable; 0 forces IDLE and masks all requests.
- ch_enable  in  NCH  per-channel enable.
- ch_dir  in  NCH  1 = TX channel, 0 = RX channel.
- fifo_level  in  NCH*LVL_W  current word count per channel, packed with ch0 in the LSBs.
- watermark  in  NCH*LVL_W  per-channel threshold.
- burst_len  in  NCH*BURST_W  beats per burst; 0 means the burst ends only on dma_done.
- timeout_limit  in  TO_W  cycles allowed between req and ack; 0 disables the timeout.
- dma_ack  in  1  DMA accepted the current request (single-cycle pulse).
- dma_beat  in  1  one word transferred for the granted channel.
- dma_done  in  1  DMA ended the burst early.
- irq_clear  in  1  clears timeout_irq and timeout_ch.
- dma_req  out  NCH  one-hot request.
- grant_id  out  3  index of the currently granted channel.
- busy  out  1  high in REQ or XFER.
- burst_done  out  1  one-cycle pulse when a burst completes.
- timeout_irq  out  1  sticky timeout flag.
- timeout_ch  out  3  channel that timed out.

Behaviour:
- Reset values: dma_req=0, grant_id=0, busy=0, burst_done=0, timeout_irq=0, timeout_ch=0, FSM=IDLE, rr_ptr=0, counters=0.
- Channel eligibility, combinational:
  - Requires ch_enable & dma_mode.
  - TX: fifo_level <= watermark.
  - RX: fifo_level >= max(watermark,1).
- FSM states:
  - IDLE:
    - If any channel is eligible, grant the first eligible channel at or after rr_ptr, wrapping modulo NCH.
    - Latch grant_id and burst_len. Go to REQ next cycle.
    - Latency: eligibility to dma_req high is 1 cycle.
  - REQ:
    - dma_req[grant_id]=1; the timeout counter increments each cycle.
    - On dma_ack: clear dma_req next cycle and go to XFER.
    - On ch_enable[grant_id]=0 or dma_mode=0 without ack: drop the request and go to IDLE; rr_ptr is unchanged.
    - On timeout counter == timeout_limit (limit != 0) without ack:
      - Set timeout_irq=1 and timeout_ch=grant_id; drop the request.
      - Set rr_ptr=grant_id+1 and go to IDLE.
    - ack and timeout in the same cycle: ack wins.
  - XFER:
    - Each dma_beat increments the beat counter.
    - The burst ends when beat_count+dma_beat == latched burst_len (len != 0), or on dma_done.
    - On end, go to DONE.
    - Disabling the channel or clearing dma_mode does not abort XFER; an in-flight DMA always completes.
    - A beat and dma_done in the same cycle count the beat and then end.
  - DONE:
    - burst_done=1 for one cycle.
    - Set rr_ptr=grant_id+1, wrapping to 0 after NCH-1. Go to IDLE.
    - The same channel may be re-granted only after every other eligible channel has had a turn.
- Beat counter saturates at all-ones when burst_len=0. It clears on entering XFER.
- dma_ack outside REQ, and dma_beat/dma_done outside XFER, are ignored.
- Timeout flag:
  - irq_clear clears timeout_irq.
  - A new timeout in the same cycle as irq_clear sets it, because set has priority.
- Reset asserted mid-operation returns everything to reset values on the next edge, regardless of state.

Decomposition:
- Shared package ble_dma_pkg:
  - FSM state encoding (IDLE, REQ, XFER, DONE).
  - Channel-index width constant, CH_W = 3.
  - TX/RX direction constants.
- Sub-module ble_rr_arbiter:
  - Combinational round-robin priority pick from an NCH eligibility vector and rr_ptr.
  - Outputs grant index and valid.

Test Plan:
- NCH=2, ch0 TX, watermark=4, level=3, burst_len=4, dma_mode=1:
  - dma_req=01 one cycle after eligibility.
  - Ack, then 4 beats → burst_done pulse on the 4th-beat cycle+1.
  - busy drops next cycle.
- Both channels eligible continuously:
  - Grants alternate 0,1,0,1 over four bursts.
  - dma_req is never two-hot.
- ch1 RX, timeout_limit=10, no ack:
  - dma_req[1] is dropped after 10 cycles; timeout_irq=1, timeout_ch=1.
  - irq_clear on the same cycle as a second timeout leaves timeout_irq=1.
- burst_len=0, ack, 3 beats, then dma_done coincident with a 4th beat:
  - Burst ends with 4 beats counted; burst_done pulses once.
- ch_enable[0] dropped in REQ:
  - Request removed next cycle; no burst_done.
- ch_enable[0] dropped in XFER:
  - Transfer completes on the burst_len beats.
- Reset pulsed while in XFER:
  - All outputs return to 0 next edge.
  - A following eligible channel is granted starting from ch0.
